// File: rtl/regs_access_ctrl.sv
// -----------------------------------------------------------------------------
// regs_access_ctrl
//
// Purpose:
//   Access controller between the pipeline and the register file. Decode reads
//   and writeback writes pass straight through to the register file. A debug
//   port shares both register-file ports. A bulk-clear sweep of x1..x31 can be
//   requested. While the controller owns the read port, it stalls the pipeline.
//
// Optional feature (macro REGS_ACCESS_STATS_EN):
//   When defined, two saturating counters are added:
//     o_stall_cycles : cycles with o_stall = 1
//     o_wb_defer_cnt : cycles where a clear or debug write lost the write port
//                      to writeback
//   When undefined, neither port nor counter exists.
//
// Ports:
//   clk              positive-edge clock
//   rst_n            asynchronous active-low reset
//   i_de_rs_rd_en    decode read enable
//   i_de_rs1/rs2     decode source addresses
//   i_wb_rd          writeback destination address
//   i_wb_wr_data     writeback write data
//   i_wb_wr_en       writeback write enable (always has the write port)
//   i_dbg_req        debug request, held until o_dbg_ack
//   i_dbg_we         1 = debug write, 0 = debug read
//   i_dbg_addr       debug register address
//   i_dbg_wdata      debug write data
//   o_dbg_ack        one-cycle completion pulse
//   o_dbg_rdata      debug read data, valid with o_dbg_ack and held afterwards
//   i_clr_req        bulk-clear request pulse
//   o_clr_busy       clear pending or in progress
//   o_stall          pipeline must hold decode
//   o_rf_rs_rd_en    register file read enable
//   o_rf_rs1/rs2     register file read addresses
//   i_rf_rs1_rd_data register file read data 1 (one cycle after read enable)
//   o_rf_rd          register file write address
//   o_rf_rd_wr_data  register file write data
//   o_rf_rd_wr_en    register file write enable
// -----------------------------------------------------------------------------
module regs_access_ctrl #(
  parameter logic [31:0] CLR_VALUE = 32'h0000_0000,
  parameter int unsigned CLR_FIRST = 1,
  parameter int unsigned CLR_LAST  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_de_rs_rd_en,
  input  logic [4:0]  i_de_rs1,
  input  logic [4:0]  i_de_rs2,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_wr_data,
  input  logic        i_wb_wr_en,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [4:0]  i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_ack,
  output logic [31:0] o_dbg_rdata,
  input  logic        i_clr_req,
  output logic        o_clr_busy,
  output logic        o_stall,
  output logic        o_rf_rs_rd_en,
  output logic [4:0]  o_rf_rs1,
  output logic [4:0]  o_rf_rs2,
  input  logic [31:0] i_rf_rs1_rd_data,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_rd_wr_data,
  output logic        o_rf_rd_wr_en
`ifdef REGS_ACCESS_STATS_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [15:0] o_wb_defer_cnt
`endif
);

  localparam logic [4:0] C_FIRST = 5'(CLR_FIRST);
  localparam logic [4:0] C_LAST  = 5'(CLR_LAST);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DBG_WR,
    RD_ISSUE,
    RD_CAP,
    RESTORE
  } state_t;

  // Registered state
  state_t      r_state;
  logic [4:0]  r_rs1_save;
  logic [4:0]  r_rs2_save;
  logic [4:0]  r_clr_cnt;
  logic        r_clr_pend;
  logic        r_dbg_pend;
  logic        r_dbg_ack;
  logic [31:0] r_dbg_rdata;
  logic        r_stall;

  // Next-state / combinational
  state_t      w_state_next;
  logic [4:0]  w_clr_cnt_next;
  logic        w_clr_pend_next;
  logic        w_dbg_pend_next;
  logic        w_dbg_ack_next;
  logic        w_rd_capture;
  logic        w_stall_next;
  logic        w_dbg_req_v;

  // The requester only drops i_dbg_req after seeing the ack, so the request is
  // still high in the ack cycle; masking it there prevents a second acceptance.
  assign w_dbg_req_v = i_dbg_req & ~r_dbg_ack;

  // ---------------------------------------------------------------------------
  // FSM next-state and port muxing
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_clr_cnt_next  = r_clr_cnt;
    w_clr_pend_next = r_clr_pend | i_clr_req;
    w_dbg_pend_next = r_dbg_pend;
    w_dbg_ack_next  = 1'b0;
    w_rd_capture    = 1'b0;

    // Outside IDLE decode is blocked; the read addresses park on the saved
    // decode addresses so the register file sees nothing new.
    o_rf_rs_rd_en   = 1'b0;
    o_rf_rs1        = r_rs1_save;
    o_rf_rs2        = r_rs2_save;

    // Writeback owns the write port whenever it asserts its enable.
    o_rf_rd         = i_wb_rd;
    o_rf_rd_wr_data = i_wb_wr_data;
    o_rf_rd_wr_en   = i_wb_wr_en;

    unique case (r_state)
      IDLE: begin
        o_rf_rs_rd_en = i_de_rs_rd_en;
        o_rf_rs1      = i_de_rs1;
        o_rf_rs2      = i_de_rs2;
        if (r_clr_pend) begin
          w_state_next    = CLEAR;
          // The sweep about to start covers any request arriving now.
          w_clr_pend_next = 1'b0;
        end else if (w_dbg_req_v && i_dbg_we) begin
          w_state_next = DBG_WR;
        end else if (w_dbg_req_v && (!i_de_rs_rd_en || r_dbg_pend)) begin
          // A pending debug read overrides decode; the stall raised for it has
          // already told the pipeline to back off.
          w_state_next    = RD_ISSUE;
          w_dbg_pend_next = 1'b0;
        end else if (w_dbg_req_v && i_de_rs_rd_en) begin
          w_dbg_pend_next = 1'b1;
        end
      end

      CLEAR: begin
        // Requests arriving during the sweep are absorbed by it.
        w_clr_pend_next = 1'b0;
        if (!i_wb_wr_en) begin
          o_rf_rd         = r_clr_cnt;
          o_rf_rd_wr_data = CLR_VALUE;
          o_rf_rd_wr_en   = 1'b1;
          if (r_clr_cnt == C_LAST) begin
            w_clr_cnt_next = C_FIRST;
            w_state_next   = IDLE;
          end else begin
            w_clr_cnt_next = r_clr_cnt + 5'd1;
          end
        end
      end

      DBG_WR: begin
        if (!i_wb_wr_en) begin
          o_rf_rd         = i_dbg_addr;
          o_rf_rd_wr_data = i_dbg_wdata;
          // x0 is hard-wired; the write is suppressed but still acknowledged.
          o_rf_rd_wr_en   = (i_dbg_addr != 5'd0);
          w_dbg_ack_next  = 1'b1;
          w_state_next    = IDLE;
        end
      end

      RD_ISSUE: begin
        o_rf_rs_rd_en = 1'b1;
        o_rf_rs1      = i_dbg_addr;
        w_state_next  = RD_CAP;
      end

      RD_CAP: begin
        w_rd_capture   = 1'b1;
        w_dbg_ack_next = 1'b1;
        w_state_next   = RESTORE;
      end

      RESTORE: begin
        // Re-read decode's last addresses so its read data is as it left it.
        o_rf_rs_rd_en = 1'b1;
        w_state_next  = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_stall_next = (w_state_next != IDLE) | w_dbg_pend_next;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rs1_save  <= 5'd0;
      r_rs2_save  <= 5'd0;
      r_clr_cnt   <= C_FIRST;
      r_clr_pend  <= 1'b0;
      r_dbg_pend  <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= 32'd0;
      r_stall     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_cnt  <= w_clr_cnt_next;
      r_clr_pend <= w_clr_pend_next;
      r_dbg_pend <= w_dbg_pend_next;
      r_dbg_ack  <= w_dbg_ack_next;
      r_stall    <= w_stall_next;
      if (r_state == IDLE && i_de_rs_rd_en) begin
        r_rs1_save <= i_de_rs1;
        r_rs2_save <= i_de_rs2;
      end
      if (w_rd_capture) begin
        r_dbg_rdata <= i_rf_rs1_rd_data;
      end
    end
  end

  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_stall     = r_stall;
  assign o_clr_busy  = r_clr_pend | (r_state == CLEAR);

`ifdef REGS_ACCESS_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [15:0] r_wb_defer_cnt;
  logic        w_wr_defer;

  // A clear or debug write wanted the port this cycle but writeback took it.
  assign w_wr_defer = i_wb_wr_en & ((r_state == CLEAR) | (r_state == DBG_WR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_wb_defer_cnt <= 16'd0;
    end else begin
      if (r_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_wr_defer && (r_wb_defer_cnt != 16'hFFFF)) begin
        r_wb_defer_cnt <= r_wb_defer_cnt + 16'd1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_wb_defer_cnt = r_wb_defer_cnt;
`endif

endmodule

// File: tb/tb_regs_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regs_access_ctrl
//
// Directed bench for regs_access_ctrl. A behavioural register file (registered
// read, write-first on same-address collision) sits on the rf_* ports and
// logs every write. Inputs change #1 after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_regs_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_rs_rd_en;
  logic [4:0]  de_rs1, de_rs2;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wr_data;
  logic        wb_wr_en;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        clr_req, clr_busy, stall;
  logic        rf_rs_rd_en;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_rd_wr_data;
  logic        rf_rd_wr_en;
`ifdef REGS_ACCESS_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] wb_defer_cnt;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [31:0] rf_mem [32];
  logic [31:0] rf_rdata1;
  logic [4:0]  log_addr [$];
  logic [31:0] log_data [$];

  always #5 clk = ~clk;

  regs_access_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_de_rs_rd_en    (de_rs_rd_en),
    .i_de_rs1         (de_rs1),
    .i_de_rs2         (de_rs2),
    .i_wb_rd          (wb_rd),
    .i_wb_wr_data     (wb_wr_data),
    .i_wb_wr_en       (wb_wr_en),
    .i_dbg_req        (dbg_req),
    .i_dbg_we         (dbg_we),
    .i_dbg_addr       (dbg_addr),
    .i_dbg_wdata      (dbg_wdata),
    .o_dbg_ack        (dbg_ack),
    .o_dbg_rdata      (dbg_rdata),
    .i_clr_req        (clr_req),
    .o_clr_busy       (clr_busy),
    .o_stall          (stall),
    .o_rf_rs_rd_en    (rf_rs_rd_en),
    .o_rf_rs1         (rf_rs1),
    .o_rf_rs2         (rf_rs2),
    .i_rf_rs1_rd_data (rf_rdata1),
    .o_rf_rd          (rf_rd),
    .o_rf_rd_wr_data  (rf_rd_wr_data),
    .o_rf_rd_wr_en    (rf_rd_wr_en)
`ifdef REGS_ACCESS_STATS_EN
    ,
    .o_stall_cycles   (stall_cycles),
    .o_wb_defer_cnt   (wb_defer_cnt)
`endif
  );

  // Register file model: preloaded to x[i] = 0x90 + i while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'h0 : 32'h90 + 32'(i);
    end else if (rf_rd_wr_en && rf_rd != 5'd0) begin
      rf_mem[rf_rd] <= rf_rd_wr_data;
    end
    if (rf_rs_rd_en) begin
      rf_rdata1 <= (rf_rd_wr_en && rf_rd == rf_rs1 && rf_rs1 != 5'd0) ? rf_rd_wr_data
                                                                       : rf_mem[rf_rs1];
    end
    if (rf_rd_wr_en) begin
      log_addr.push_back(rf_rd);
      log_data.push_back(rf_rd_wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Debug read; lat counts cycles from the request cycle to the ack cycle.
  task automatic dbg_read(input logic [4:0] addr, output int lat,
                          output logic [31:0] data, output logic st1);
    bit got;
    got = 0;
    lat = 0;
    st1 = 1'b0;
    dbg_req  = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = addr;
    while (!got && lat < 12) begin
      @(negedge clk);
      if (lat == 1) st1 = stall;
      if (dbg_ack) got = 1;
      else begin
        step();
        lat++;
      end
    end
    data = dbg_rdata;
    step();
    dbg_req = 1'b0;
    $display("dbg read  x%0d -> %h latency %0d", addr, data, lat);
  endtask

  // Clear sweep with optional writeback on three sweep cycles; counts busy and
  // stall cycles from the cycle after the request.
  task automatic run_clear(input bit with_wb, output int busy, output int stl);
    busy = 0;
    stl  = 0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int n = 0; n < 45; n++) begin
      wb_wr_en   = 1'b0;
      if (with_wb && (n == 4 || n == 9 || n == 19)) begin
        wb_wr_en   = 1'b1;
        wb_rd      = (n == 4) ? 5'd10 : (n == 9) ? 5'd20 : 5'd2;
        wb_wr_data = 32'hA000_0000 + 32'(n);
      end
      @(negedge clk);
      if (clr_busy) busy++;
      if (stall) stl++;
      step();
    end
    wb_wr_en = 1'b0;
    $display("clear sweep wb=%0d busy=%0d stall=%0d writes=%0d", with_wb, busy, stl, log_addr.size());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, busy, stl, exp_idx, wbi;
    logic [31:0] rd;
    logic        st1;
    logic [4:0]  wb_exp_addr [3];
    logic [31:0] wb_exp_data [3];

    rst_n = 1'b0; de_rs_rd_en = 1'b0; de_rs1 = '0; de_rs2 = '0;
    wb_rd = '0; wb_wr_data = '0; wb_wr_en = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; clr_req = 1'b0;
    repeat (3) step();

    // Reset values
    @(negedge clk);
    check_val("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check_val("rst_dbg_rdata", dbg_rdata, 32'd0);
    check_val("rst_clr_busy", 32'(clr_busy), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Writeback passthrough: x9 <= 0x12345678
    wb_wr_en = 1'b1; wb_rd = 5'd9; wb_wr_data = 32'h1234_5678;
    @(negedge clk);
    check_val("wb_pass_en", 32'(rf_rd_wr_en), 32'd1);
    check_val("wb_pass_rd", 32'(rf_rd), 32'd9);
    check_val("wb_pass_data", rf_rd_wr_data, 32'h1234_5678);
    $display("wb write  x9 <- 12345678");
    step();
    wb_wr_en = 1'b0;
    step();

    // Decode read 3/4, then debug read of x7 (holds 0x97)
    de_rs_rd_en = 1'b1; de_rs1 = 5'd3; de_rs2 = 5'd4;
    @(negedge clk);
    check_val("de_pass_en", 32'(rf_rs_rd_en), 32'd1);
    check_val("de_pass_rs1", 32'(rf_rs1), 32'd3);
    check_val("de_pass_rs2", 32'(rf_rs2), 32'd4);
    step();                                   // T
    de_rs_rd_en = 1'b0; de_rs1 = 5'd20; de_rs2 = 5'd21;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
    @(negedge clk);
    check_val("rd7_stall_T", 32'(stall), 32'd0);
    step();                                   // T+1 RD_ISSUE
    @(negedge clk);
    check_val("rd7_issue_en", 32'(rf_rs_rd_en), 32'd1);
    check_val("rd7_issue_rs1", 32'(rf_rs1), 32'd7);
    check_val("rd7_stall_T1", 32'(stall), 32'd1);
    step();                                   // T+2 RD_CAP
    @(negedge clk);
    check_val("rd7_cap_en", 32'(rf_rs_rd_en), 32'd0);
    check_val("rd7_ack_T2", 32'(dbg_ack), 32'd0);
    step();                                   // T+3 RESTORE
    @(negedge clk);
    check_val("rd7_ack_T3", 32'(dbg_ack), 32'd1);
    check_val("rd7_rdata", dbg_rdata, 32'h97);
    check_val("rd7_restore_en", 32'(rf_rs_rd_en), 32'd1);
    check_val("rd7_restore_rs1", 32'(rf_rs1), 32'd3);
    check_val("rd7_restore_rs2", 32'(rf_rs2), 32'd4);
    step();                                   // T+4 IDLE
    dbg_req = 1'b0;
    @(negedge clk);
    check_val("rd7_stall_T4", 32'(stall), 32'd0);
    check_val("rd7_ack_T4", 32'(dbg_ack), 32'd0);
`ifdef REGS_ACCESS_STATS_EN
    check_val("stat_stall_cycles", stall_cycles, 32'd3);
`endif
    $display("dbg read  x7 -> %h (restore 3/4)", dbg_rdata);
    step();

    // Debug write x5 <= DEADBEEF, then read it back
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEAD_BEEF;   // T
    step();                                   // T+1
    @(negedge clk);
    check_val("dwr_en", 32'(rf_rd_wr_en), 32'd1);
    check_val("dwr_rd", 32'(rf_rd), 32'd5);
    check_val("dwr_data", rf_rd_wr_data, 32'hDEAD_BEEF);
    check_val("dwr_ack_T1", 32'(dbg_ack), 32'd0);
    step();                                   // T+2
    @(negedge clk);
    check_val("dwr_ack_T2", 32'(dbg_ack), 32'd1);
    step();                                   // T+3
    dbg_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    check_val("dwr_ack_T3", 32'(dbg_ack), 32'd0);
    $display("dbg write x5 <- deadbeef");
    step();
    dbg_read(5'd5, lat, rd, st1);
    check_val("rd5_latency", 32'(lat), 32'd3);
    check_val("rd5_data", rd, 32'hDEAD_BEEF);
    step();

    // Debug read while decode reads continuously: pending path
    de_rs_rd_en = 1'b1; de_rs1 = 5'd1; de_rs2 = 5'd2;
    dbg_read(5'd9, lat, rd, st1);
    check_val("rd9_stall_next", 32'(st1), 32'd1);
    check_val("rd9_latency", 32'(lat), 32'd4);
    check_val("rd9_data", rd, 32'h1234_5678);
    de_rs_rd_en = 1'b0;
    step();

    // Writeback to the address being debug-read, in the RD_ISSUE cycle
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd12;   // T
    step();                                   // T+1
    wb_wr_en = 1'b1; wb_rd = 5'd12; wb_wr_data = 32'hCAFE_F00D;
    step();                                   // T+2
    wb_wr_en = 1'b0;
    step();                                   // T+3
    @(negedge clk);
    check_val("rd12_ack", 32'(dbg_ack), 32'd1);
    check_val("rd12_new_data", dbg_rdata, 32'hCAFE_F00D);
    $display("dbg read  x12 -> %h (wb collision)", dbg_rdata);
    step();
    dbg_req = 1'b0;
    step();

    // Clear sweep, no writeback
    log_addr.delete(); log_data.delete();
    run_clear(1'b0, busy, stl);
    check_val("clrA_busy_cycles", 32'(busy), 32'd32);
    check_val("clrA_stall_cycles", 32'(stl), 32'd31);
    check_val("clrA_write_count", 32'(log_addr.size()), 32'd31);
    for (int i = 0; i < log_addr.size() && i < 31; i++) begin
      check_val("clrA_addr", 32'(log_addr[i]), 32'(i + 1));
      check_val("clrA_data", log_data[i], 32'd0);
    end
    check_val("clrA_x5", rf_mem[5], 32'd0);
    check_val("clrA_x31", rf_mem[31], 32'd0);
`ifdef REGS_ACCESS_STATS_EN
    check_val("stat_defer_A", 32'(wb_defer_cnt), 32'd0);
`endif

    // Clear sweep with three writebacks interleaved
    wb_exp_addr[0] = 5'd10; wb_exp_data[0] = 32'hA000_0004;
    wb_exp_addr[1] = 5'd20; wb_exp_data[1] = 32'hA000_0009;
    wb_exp_addr[2] = 5'd2;  wb_exp_data[2] = 32'hA000_0013;
    log_addr.delete(); log_data.delete();
    run_clear(1'b1, busy, stl);
    check_val("clrB_busy_cycles", 32'(busy), 32'd35);
    check_val("clrB_sweep_cycles", 32'(stl), 32'd34);
    exp_idx = 1;
    wbi = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_data[i] == 32'd0) begin
        check_val("clrB_addr", 32'(log_addr[i]), 32'(exp_idx));
        exp_idx++;
      end else if (wbi < 3) begin
        check_val("clrB_wb_addr", 32'(log_addr[i]), 32'(wb_exp_addr[wbi]));
        check_val("clrB_wb_data", log_data[i], wb_exp_data[wbi]);
        wbi++;
      end else begin
        wbi++;
      end
    end
    check_val("clrB_clear_writes", 32'(exp_idx - 1), 32'd31);
    check_val("clrB_wb_writes", 32'(wbi), 32'd3);
    check_val("clrB_x20_final", rf_mem[20], 32'd0);
    check_val("clrB_x2_final", rf_mem[2], 32'hA000_0013);
`ifdef REGS_ACCESS_STATS_EN
    check_val("stat_defer_B", 32'(wb_defer_cnt), 32'd3);
`endif
    step();

    // Reset during RD_CAP with a clear pending
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;   // T
    step();                                   // T+1 RD_ISSUE
    clr_req = 1'b1;
    step();                                   // T+2 RD_CAP
    clr_req = 1'b0;
    check_val("rstmid_busy_before", 32'(clr_busy), 32'd1);
    check_val("rstmid_stall_before", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstmid_dbg_ack", 32'(dbg_ack), 32'd0);
    check_val("rstmid_dbg_rdata", dbg_rdata, 32'd0);
    check_val("rstmid_clr_busy", 32'(clr_busy), 32'd0);
    check_val("rstmid_stall", 32'(stall), 32'd0);
    dbg_req = 1'b0;
    step();
    rst_n = 1'b1;
    busy = 0;
    lat = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (dbg_ack) lat++;
      if (clr_busy || stall) busy++;
      step();
    end
    check_val("rstmid_no_ack", 32'(lat), 32'd0);
    check_val("rstmid_idle_after", 32'(busy), 32'd0);
    de_rs_rd_en = 1'b1; de_rs1 = 5'd6; de_rs2 = 5'd8;
    @(negedge clk);
    check_val("rstmid_pass_en", 32'(rf_rs_rd_en), 32'd1);
    check_val("rstmid_pass_rs1", 32'(rf_rs1), 32'd6);
`ifdef REGS_ACCESS_STATS_EN
    check_val("rstmid_stat_defer", 32'(wb_defer_cnt), 32'd0);
`endif
    $display("reset mid-read: dropped, controller idle");
    step();
    de_rs_rd_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regs_access_ctrl.md
Name: regs_access_ctrl

Overview:
Access controller between the pipeline and the register file.
- Passes decode read requests and writeback writes through to the register file.
- Shares the register file's read and write ports with a debug read/write port.
- Sequences a bulk-clear sweep of x1..x31.
- Drives a stall to the pipeline while it owns the read port.

Parameters:
CLR_VALUE, 32'h0000_0000, value written to each register during a clear sweep
CLR_FIRST, 1, first register index swept (x0 is never written)
CLR_LAST, 31, last register index swept

Ports:
clk  in  1  positive-edge system clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
de_rs_rd_en  in  1  decode read enable
de_rs1  in  5  decode source register 1 address
de_rs2  in  5  decode source register 2 address
wb_rd  in  5  writeback destination address
wb_wr_data  in  32  writeback write data
wb_wr_en  in  1  writeback write enable
dbg_req  in  1  debug request; held high until dbg_ack
dbg_we  in  1  1 = debug write, 0 = debug read
dbg_addr  in  5  debug register address
dbg_wdata  in  32  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  32  debug read data, valid with dbg_ack and held afterwards
clr_req  in  1  bulk-clear request pulse
clr_busy  out  1  clear pending or in progress
stall  out  1  pipeline must hold decode while high
rf_rs_rd_en  out  1  register file read enable
rf_rs1  out  5  register file read address 1
rf_rs2  out  5  register file read address 2
rf_rs1_rd_data  in  32  register file read data 1
rf_rd  out  5  register file write address
rf_rd_wr_data  out  32  register file write data
rf_rd_wr_en  out  1  register file write enable

Behaviour:
- Reset values:
  - outputs: dbg_ack=0, dbg_rdata=0, clr_busy=0, stall=0.
  - internal state: state=IDLE, saved rs1/rs2=0, clear counter=CLR_FIRST, pending flags=0.
- Register file read is registered-address: data appears one cycle after rf_rs_rd_en.
- Write port priority: wb_wr_en always wins, in the same cycle and combinationally; it is never delayed or dropped. Clear and debug writes use the write port only in cycles where wb_wr_en=0.
- Read port, IDLE: rf_rs_rd_en/rf_rs1/rf_rs2 = de_* combinationally. Whenever de_rs_rd_en=1, the controller saves de_rs1/de_rs2.
- Read port, non-IDLE: decode is blocked, so rf_rs_rd_en is driven only by the FSM.
- stall is registered and equals (next state != IDLE) | dbg_pend. dbg_pend is set when dbg_req arrives in IDLE while de_rs_rd_en=1; this prevents decode from starving debug.
- FSM states: IDLE, CLEAR, DBG_WR, RD_ISSUE, RD_CAP, RESTORE.
- IDLE selection, in priority order:
  - clear pending -> CLEAR.
  - else dbg_req & dbg_we -> DBG_WR.
  - else dbg_req & !dbg_we & !de_rs_rd_en -> RD_ISSUE.
- CLEAR:
  - Each cycle with wb_wr_en=0: write CLR_VALUE to x[counter], then increment.
  - Cycles with wb_wr_en=1: no clear write, counter holds.
  - After writing CLR_LAST: counter returns to CLR_FIRST, clr_busy drops the next cycle, go to IDLE.
- clr_req in any state sets clear pending. clr_busy = pending | CLEAR. A clr_req during CLEAR is absorbed, not re-queued.
- DBG_WR:
  - First cycle with wb_wr_en=0: write dbg_wdata to dbg_addr, pulse dbg_ack the next cycle, go to IDLE.
  - dbg_addr=0: no rf_rd_wr_en, still acked.
- Debug read timing (dbg_req accepted in cycle T):
  - T+1 RD_ISSUE: rf_rs_rd_en=1, rf_rs1=dbg_addr.
  - T+2 RD_CAP: dbg_rdata <= rf_rs1_rd_data, dbg_ack=1 at T+3.
  - T+3 RESTORE: rf_rs_rd_en=1 with the saved rs1/rs2, so decode's read data is unchanged.
  - T+4 IDLE.
- Simultaneous wb write to the address being debug-read: it lands before RD_CAP, so dbg_rdata returns the new value.
- Reset mid-operation: FSM returns to IDLE. Any in-flight debug transfer is dropped with no ack, and pending clear is discarded.

Optional Feature:
- Macro: REGS_ACCESS_STATS_EN.
- Defined: adds output stall_cycles[31:0], a saturating count of cycles with stall=1, reset to 0.
- Defined: adds output wb_defer_cnt[15:0], a saturating count of cycles where a clear or debug write was deferred by wb_wr_en, reset to 0.
- Undefined: neither port nor counter exists.

Test Plan:
- clr_req pulse with no writeback:
  - clr_busy high for 32 cycles (1 pending + 31 writes).
  - rf writes x1..x31 = 0 in order.
  - stall high throughout.
- clr_req with wb_wr_en=1 on 3 sweep cycles:
  - sweep lasts 34 cycles.
  - all 3 wb writes reach rf unchanged; no index skipped.
- Debug write dbg_addr=5, dbg_wdata=32'hDEAD_BEEF, wb idle:
  - rf_rd=5, write enabled at T+1.
  - dbg_ack at T+2.
  - a subsequent debug read of x5 returns 32'hDEADBEEF.
- Decode reads rs1=3/rs2=4, then debug read of x7 (holding 32'h97):
  - dbg_rdata=32'h97 with dbg_ack at T+3.
  - RESTORE reissues 3/4; stall drops at T+4.
- dbg_req read while de_rs_rd_en=1 continuously: stall rises next cycle, then read completes with normal latency.
- rst_n low during RD_CAP: all outputs at reset values immediately, no dbg_ack, FSM in IDLE after release.
